// File: rtl/goldsmith_div_sched_if.sv
// Client, response and datapath signals of the Goldschmidt divider scheduler.
// slave = scheduler side; master = requesters plus the divider datapath.
interface goldsmith_div_sched_if;
    logic        req0_valid;
    logic        req1_valid;
    logic        req0_ready;
    logic        req1_ready;
    logic [31:0] req0_dividend;
    logic [31:0] req0_divisor;
    logic [31:0] req1_dividend;
    logic [31:0] req1_divisor;

    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    logic        dp_reset;
    logic        dp_start;
    logic [31:0] dp_dividend;
    logic [31:0] dp_divisor;
    logic [31:0] dp_out;

    modport slave (
        input  req0_valid, req1_valid,
        input  req0_dividend, req0_divisor, req1_dividend, req1_divisor,
        input  dp_out,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy,
        output dp_reset, dp_start, dp_dividend, dp_divisor
    );

    modport master (
        output req0_valid, req1_valid,
        output req0_dividend, req0_divisor, req1_dividend, req1_divisor,
        output dp_out,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy,
        input  dp_reset, dp_start, dp_dividend, dp_divisor
    );
endinterface

// File: rtl/goldsmith_div_sched.sv
// Round-robin scheduler/sequencer for a shared Goldschmidt divider (Q9.23).
// Optional divide-by-zero short-cut: define GSD_DIVZERO_CHK_EN.
module goldsmith_div_sched #(
    parameter int unsigned ITERS = 4
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    goldsmith_div_sched_if.slave        io_bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [3:0] LAST_CNT = 4'(ITERS - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_d;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_d;
    logic        r_ptr;
    logic        w_ptr_d;
    logic [31:0] r_op_dividend;
    logic [31:0] w_op_dividend_d;
    logic [31:0] r_op_divisor;
    logic [31:0] w_op_divisor_d;
    logic        r_op_id;
    logic        w_op_id_d;
    logic [31:0] r_rsp_data;
    logic [31:0] w_rsp_data_d;
`ifdef GSD_DIVZERO_CHK_EN
    logic        r_rsp_err;
    logic        w_rsp_err_d;
`endif

    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_xfer;
    logic [31:0] w_sel_dividend;
    logic [31:0] w_sel_divisor;

    // r_ptr holds the last granted ID; a tie goes to the other requester.
    assign w_idle   = (r_state == ST_IDLE) && !i_reset;
    assign w_grant0 = w_idle && io_bus.req0_valid && (!io_bus.req1_valid || r_ptr);
    assign w_grant1 = w_idle && io_bus.req1_valid && (!io_bus.req0_valid || !r_ptr);
    assign w_xfer   = w_grant0 || w_grant1;

    assign w_sel_dividend = w_grant1 ? io_bus.req1_dividend : io_bus.req0_dividend;
    assign w_sel_divisor  = w_grant1 ? io_bus.req1_divisor  : io_bus.req0_divisor;

    always_comb begin
        w_state_d       = r_state;
        w_cnt_d         = r_cnt;
        w_ptr_d         = r_ptr;
        w_op_dividend_d = r_op_dividend;
        w_op_divisor_d  = r_op_divisor;
        w_op_id_d       = r_op_id;
        w_rsp_data_d    = r_rsp_data;
`ifdef GSD_DIVZERO_CHK_EN
        w_rsp_err_d     = r_rsp_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_ptr_d         = w_grant1;
                    w_op_id_d       = w_grant1;
                    w_op_dividend_d = w_sel_dividend;
                    w_op_divisor_d  = w_sel_divisor;
`ifdef GSD_DIVZERO_CHK_EN
                    // Zero divisor never touches the datapath.
                    if (w_sel_divisor == '0) begin
                        w_state_d    = ST_DONE;
                        w_rsp_data_d = '1;
                        w_rsp_err_d  = 1'b1;
                    end else begin
                        w_state_d    = ST_LOAD;
                        w_rsp_err_d  = 1'b0;
                    end
`else
                    w_state_d       = ST_LOAD;
`endif
                end
            end
            ST_LOAD: begin
                w_cnt_d   = '0;
                w_state_d = ST_ITER;
            end
            ST_ITER: begin
                w_cnt_d = r_cnt + 4'd1;
                if (r_cnt == LAST_CNT) begin
                    w_rsp_data_d = io_bus.dp_out;
                    w_state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_ptr         <= 1'b1;
            r_op_dividend <= '0;
            r_op_divisor  <= '0;
            r_op_id       <= 1'b0;
            r_rsp_data    <= '0;
`ifdef GSD_DIVZERO_CHK_EN
            r_rsp_err     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_d;
            r_cnt         <= w_cnt_d;
            r_ptr         <= w_ptr_d;
            r_op_dividend <= w_op_dividend_d;
            r_op_divisor  <= w_op_divisor_d;
            r_op_id       <= w_op_id_d;
            r_rsp_data    <= w_rsp_data_d;
`ifdef GSD_DIVZERO_CHK_EN
            r_rsp_err     <= w_rsp_err_d;
`endif
        end
    end

    assign io_bus.req0_ready  = w_grant0;
    assign io_bus.req1_ready  = w_grant1;
    assign io_bus.rsp_valid   = (r_state == ST_DONE);
    assign io_bus.rsp_id      = r_op_id;
    assign io_bus.rsp_data    = r_rsp_data;
`ifdef GSD_DIVZERO_CHK_EN
    assign io_bus.rsp_err     = r_rsp_err;
`else
    assign io_bus.rsp_err     = 1'b0;
`endif
    assign io_bus.busy        = (r_state != ST_IDLE);
    assign io_bus.dp_reset    = i_reset;
    assign io_bus.dp_start    = (r_state == ST_LOAD);
    assign io_bus.dp_dividend = r_op_dividend;
    assign io_bus.dp_divisor  = r_op_divisor;

endmodule

// File: tb/tb_goldsmith_div_sched.sv
// Directed bench for goldsmith_div_sched: three instances (ITERS 4, 2, 1), each
// driving a small behavioural Goldschmidt datapath.
module tb_goldsmith_div_sched;

    logic clk = 1'b0;
    logic reset;
    int   n_checks;
    int   n_errors;

    always #5 clk = ~clk;

    goldsmith_div_sched_if b4 ();
    goldsmith_div_sched_if b2 ();
    goldsmith_div_sched_if b1 ();

    goldsmith_div_sched #(.ITERS(4)) u_dut4 (.i_clk(clk), .i_reset(reset), .io_bus(b4));
    goldsmith_div_sched #(.ITERS(2)) u_dut2 (.i_clk(clk), .i_reset(reset), .io_bus(b2));
    goldsmith_div_sched #(.ITERS(1)) u_dut1 (.i_clk(clk), .i_reset(reset), .io_bus(b1));

    // Datapath model: normalise D into [0.5,1), linear seed F0 = 2.9142 - 2D,
    // then N,D <= N*(2-D), D*(2-D) every clock; dp_out is the next N estimate.
    localparam logic [63:0] TWO = 64'd16777216;
    localparam logic [63:0] F0C = 64'd24446081;

    function automatic logic [63:0] gs_step(input logic [63:0] x, input logic [63:0] d);
        return (x * (TWO - d)) >> 23;
    endfunction

    function automatic int gs_shift(input logic [31:0] d);
        int          s;
        logic [31:0] t;
        s = 0;
        t = d;
        for (int i = 0; i < 10; i++) begin
            if (t >= 32'h0080_0000) begin
                t = t >> 1;
                s++;
            end
        end
        return s;
    endfunction

    function automatic logic [63:0] gs_load(input logic [31:0] x, input logic [31:0] d);
        int          s;
        logic [63:0] dn;
        logic [63:0] f0;
        s  = gs_shift(d);
        dn = 64'(d) >> s;
        f0 = F0C - 2 * dn;
        return ((64'(x) >> s) * f0) >> 23;
    endfunction

    logic [63:0] m4_n = '0, m4_d = '0;
    logic [63:0] m2_n = '0, m2_d = '0;
    logic [63:0] m1_n = '0, m1_d = '0;

    always @(posedge clk) begin
        if (b4.dp_reset) begin
            m4_n <= '0;
            m4_d <= '0;
        end else if (b4.dp_start) begin
            m4_n <= gs_load(b4.dp_dividend, b4.dp_divisor);
            m4_d <= gs_load(b4.dp_divisor, b4.dp_divisor);
        end else begin
            m4_n <= gs_step(m4_n, m4_d);
            m4_d <= gs_step(m4_d, m4_d);
        end
    end

    always @(posedge clk) begin
        if (b2.dp_reset) begin
            m2_n <= '0;
            m2_d <= '0;
        end else if (b2.dp_start) begin
            m2_n <= gs_load(b2.dp_dividend, b2.dp_divisor);
            m2_d <= gs_load(b2.dp_divisor, b2.dp_divisor);
        end else begin
            m2_n <= gs_step(m2_n, m2_d);
            m2_d <= gs_step(m2_d, m2_d);
        end
    end

    always @(posedge clk) begin
        if (b1.dp_reset) begin
            m1_n <= '0;
            m1_d <= '0;
        end else if (b1.dp_start) begin
            m1_n <= gs_load(b1.dp_dividend, b1.dp_divisor);
            m1_d <= gs_load(b1.dp_divisor, b1.dp_divisor);
        end else begin
            m1_n <= gs_step(m1_n, m1_d);
            m1_d <= gs_step(m1_d, m1_d);
        end
    end

    assign b4.dp_out = 32'(gs_step(m4_n, m4_d));
    assign b2.dp_out = 32'(gs_step(m2_n, m2_d));
    assign b1.dp_out = 32'(gs_step(m1_n, m1_d));

    // Inputs change at edge+1, outputs are sampled at edge+2.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (b4.dp_reset !== 1'b1) begin
            n_errors++; $display("FAIL reset_dp_reset_hi: got %b want 1", b4.dp_reset);
        end
        n_checks++;
        if (b4.busy !== 1'b0 || b4.rsp_valid !== 1'b0 || b4.dp_start !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy=%b rsp_valid=%b dp_start=%b want 0 0 0",
                     b4.busy, b4.rsp_valid, b4.dp_start);
        end
        n_checks++;
        if (b4.rsp_data !== 32'h0 || b4.dp_dividend !== 32'h0 || b4.rsp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_data: rsp_data=%h dp_dividend=%h rsp_err=%b want 0 0 0",
                     b4.rsp_data, b4.dp_dividend, b4.rsp_err);
        end
        reset = 1'b0;
        tick();
        #1;
        n_checks++;
        if (b4.dp_reset !== 1'b0 || b4.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: dp_reset=%b busy=%b want 0 0", b4.dp_reset, b4.busy);
        end
        tick();
    endtask

    task automatic test_single();
        logic [31:0] d;
        b4.req0_dividend = 32'h0300_0000;
        b4.req0_divisor  = 32'h0100_0000;
        b4.req0_valid    = 1'b1;
        #1;
        n_checks++;
        if (b4.req0_ready !== 1'b1 || b4.req1_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL single_grant: ready0=%b ready1=%b want 1 0",
                     b4.req0_ready, b4.req1_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            b4.req0_valid = 1'b0;
            #1;
            n_checks++;
            if (b4.dp_start !== (k == 1)) begin
                n_errors++; $display("FAIL single_dp_start A+%0d: got %b", k, b4.dp_start);
            end
            n_checks++;
            if (b4.rsp_valid !== (k == 6)) begin
                n_errors++; $display("FAIL single_rsp_valid A+%0d: got %b", k, b4.rsp_valid);
            end
            n_checks++;
            if (b4.busy !== (k <= 6)) begin
                n_errors++; $display("FAIL single_busy A+%0d: got %b", k, b4.busy);
            end
            if (k == 1) begin
                n_checks++;
                if (b4.dp_dividend !== 32'h0300_0000 || b4.dp_divisor !== 32'h0100_0000) begin
                    n_errors++;
                    $display("FAIL single_operands: got %h/%h want 03000000/01000000",
                             b4.dp_dividend, b4.dp_divisor);
                end
            end
            if (k == 6) begin
                d = b4.rsp_data;
                n_checks++;
                if ($isunknown(d) || d < 32'h017F_FFF0 || d > 32'h0180_0010) begin
                    n_errors++;
                    $display("FAIL single_rsp_data: got %h want 01800000 +-10", d);
                end
                n_checks++;
                if (b4.rsp_id !== 1'b0 || b4.rsp_err !== 1'b0) begin
                    n_errors++;
                    $display("FAIL single_rsp_id_err: got %b %b want 0 0",
                             b4.rsp_id, b4.rsp_err);
                end
            end
        end
        tick();
    endtask

    task automatic test_tie();
        int          g_id[4];
        int          g_cyc[4];
        int          r_id[4];
        int          gn;
        int          rn;
        int          viol;
        logic [31:0] r1_data;
        gn = 0; rn = 0; viol = 0; r1_data = '0;
        reset = 1'b1;
        b4.req0_dividend = 32'h0300_0000; b4.req0_divisor = 32'h0100_0000;
        b4.req1_dividend = 32'h0100_0000; b4.req1_divisor = 32'h0080_0000;
        b4.req0_valid = 1'b1;
        b4.req1_valid = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin
                tick();
                #1;
            end
            if (b4.busy && (b4.req0_ready || b4.req1_ready)) viol++;
            if (gn < 4 && (b4.req0_ready || b4.req1_ready)) begin
                g_id[gn]  = b4.req1_ready ? 1 : 0;
                g_cyc[gn] = c;
                gn++;
            end
            if (rn < 4 && b4.rsp_valid) begin
                r_id[rn] = int'(b4.rsp_id);
                if (b4.rsp_id) r1_data = b4.rsp_data;
                rn++;
            end
        end
        tick();
        b4.req0_valid = 1'b0;
        b4.req1_valid = 1'b0;
        n_checks++;
        if (gn != 2) begin
            n_errors++; $display("FAIL tie_grant_count: got %0d want 2", gn);
        end else begin
            n_checks++;
            if (g_id[0] != 0 || g_cyc[0] != 0) begin
                n_errors++;
                $display("FAIL tie_first: id %0d at %0d want id 0 at 0", g_id[0], g_cyc[0]);
            end
            n_checks++;
            if (g_id[1] != 1 || g_cyc[1] != 7) begin
                n_errors++;
                $display("FAIL tie_second: id %0d at %0d want id 1 at 7", g_id[1], g_cyc[1]);
            end
        end
        n_checks++;
        if (rn != 2 || r_id[0] != 0 || r_id[1] != 1) begin
            n_errors++;
            $display("FAIL tie_rsp_ids: count %0d ids %0d,%0d want 2 responses 0,1",
                     rn, r_id[0], r_id[1]);
        end
        n_checks++;
        if (viol != 0) begin
            n_errors++; $display("FAIL tie_ready_while_busy: got %0d cycles want 0", viol);
        end
        n_checks++;
        if ($isunknown(r1_data) || r1_data < 32'h00FF_FFF0 || r1_data > 32'h0100_0010) begin
            n_errors++; $display("FAIL tie_rsp1_data: got %h want 01000000 +-10", r1_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int xfers;
        int t[3];
        int pulses;
        int bad_id;
        int first_rsp;
        int r0;
        xfers = 0; pulses = 0; bad_id = 0; first_rsp = -1; r0 = 0;
        b2.req1_dividend = 32'h0100_0000;
        b2.req1_divisor  = 32'h0100_0000;
        b2.req1_valid    = 1'b1;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) begin
                tick();
                if (xfers >= 3) b2.req1_valid = 1'b0;
                #1;
            end
            if (b2.req1_ready && b2.req1_valid) begin
                if (xfers < 3) t[xfers] = c;
                xfers++;
            end
            if (b2.req0_ready) r0++;
            if (b2.rsp_valid) begin
                if (first_rsp < 0) first_rsp = c;
                pulses++;
                if (b2.rsp_id !== 1'b1) bad_id++;
            end
        end
        n_checks++;
        if (xfers != 3) begin
            n_errors++; $display("FAIL b2b_xfers: got %0d want 3", xfers);
        end else begin
            n_checks++;
            if (t[1] - t[0] != 5 || t[2] - t[1] != 5) begin
                n_errors++;
                $display("FAIL b2b_spacing: got %0d,%0d want 5,5", t[1] - t[0], t[2] - t[1]);
            end
        end
        n_checks++;
        if (pulses != 3 || bad_id != 0) begin
            n_errors++;
            $display("FAIL b2b_rsp: pulses %0d bad ids %0d want 3 and 0", pulses, bad_id);
        end
        n_checks++;
        if (first_rsp != 4) begin
            n_errors++; $display("FAIL b2b_latency: first rsp at %0d want 4", first_rsp);
        end
        n_checks++;
        if (r0 != 0) begin
            n_errors++; $display("FAIL b2b_ready0: got %0d cycles want 0", r0);
        end
        tick();
    endtask

    task automatic test_divzero();
        int          rsp_k;
        int          rsp_n;
        logic        start_seen;
        logic [31:0] data;
        logic        err;
        rsp_k = -1; rsp_n = 0; start_seen = 1'b0; data = '0; err = 1'b0;
        b4.req0_dividend = 32'h0080_0000;
        b4.req0_divisor  = 32'h0000_0000;
        b4.req0_valid    = 1'b1;
        #1;
        n_checks++;
        if (b4.req0_ready !== 1'b1) begin
            n_errors++; $display("FAIL dz_grant: got %b want 1", b4.req0_ready);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            b4.req0_valid = 1'b0;
            #1;
            if (b4.dp_start === 1'b1) start_seen = 1'b1;
            if (b4.rsp_valid === 1'b1) begin
                rsp_n++;
                rsp_k = k;
                data  = b4.rsp_data;
                err   = b4.rsp_err;
            end
        end
        n_checks++;
        if (rsp_n != 1) begin
            n_errors++; $display("FAIL dz_rsp_count: got %0d want 1", rsp_n);
        end
`ifdef GSD_DIVZERO_CHK_EN
        n_checks++;
        if (rsp_k != 1 || start_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL dz_timing: rsp at A+%0d dp_start seen %b want A+1 and 0",
                     rsp_k, start_seen);
        end
        n_checks++;
        if (data !== 32'hFFFF_FFFF || err !== 1'b1) begin
            n_errors++; $display("FAIL dz_data: got %h err %b want ffffffff err 1", data, err);
        end
`else
        n_checks++;
        if (rsp_k != 6 || start_seen !== 1'b1) begin
            n_errors++;
            $display("FAIL dz_timing: rsp at A+%0d dp_start seen %b want A+6 and 1",
                     rsp_k, start_seen);
        end
        n_checks++;
        if (err !== 1'b0) begin
            n_errors++; $display("FAIL dz_err: got %b want 0", err);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid_iter();
        int rsp_n;
        rsp_n = 0;
        b4.req0_dividend = 32'h0300_0000;
        b4.req0_divisor  = 32'h0100_0000;
        b4.req0_valid    = 1'b1;
        #1;
        n_checks++;
        if (b4.req0_ready !== 1'b1) begin
            n_errors++; $display("FAIL rmid_grant: got %b want 1", b4.req0_ready);
        end
        tick();
        b4.req0_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (b4.busy !== 1'b1 || b4.dp_reset !== 1'b1) begin
            n_errors++;
            $display("FAIL rmid_pre: busy=%b dp_reset=%b want 1 1", b4.busy, b4.dp_reset);
        end
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (b4.busy !== 1'b0 || b4.rsp_valid !== 1'b0 || b4.dp_start !== 1'b0 ||
            b4.rsp_id !== 1'b0 || b4.rsp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL rmid_ctrl: busy=%b rsp_valid=%b dp_start=%b id=%b err=%b want 0",
                     b4.busy, b4.rsp_valid, b4.dp_start, b4.rsp_id, b4.rsp_err);
        end
        n_checks++;
        if (b4.rsp_data !== 32'h0 || b4.dp_dividend !== 32'h0 || b4.dp_divisor !== 32'h0) begin
            n_errors++;
            $display("FAIL rmid_data: rsp_data=%h dp_dividend=%h dp_divisor=%h want 0",
                     b4.rsp_data, b4.dp_dividend, b4.dp_divisor);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            #1;
            if (b4.rsp_valid !== 1'b0) rsp_n++;
        end
        n_checks++;
        if (rsp_n != 0) begin
            n_errors++; $display("FAIL rmid_no_rsp: got %0d pulses want 0", rsp_n);
        end
        tick();
        b4.req0_valid = 1'b1;
        b4.req1_valid = 1'b1;
        #1;
        n_checks++;
        if (b4.req0_ready !== 1'b1 || b4.req1_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL rmid_tie_ptr: ready0=%b ready1=%b want 1 0",
                     b4.req0_ready, b4.req1_ready);
        end
        b4.req0_valid = 1'b0;
        b4.req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_iters1();
        logic [31:0] est;
        b1.req0_dividend = 32'h0300_0000;
        b1.req0_divisor  = 32'h0100_0000;
        b1.req0_valid    = 1'b1;
        #1;
        n_checks++;
        if (b1.req0_ready !== 1'b1) begin
            n_errors++; $display("FAIL it1_grant: got %b want 1", b1.req0_ready);
        end
        tick();
        b1.req0_valid = 1'b0;
        tick();
        #1;
        est = b1.dp_out;
        n_checks++;
        if (b1.rsp_valid !== 1'b0 || $isunknown(est) ||
            est < 32'h0170_0000 || est > 32'h0190_0000) begin
            n_errors++;
            $display("FAIL it1_a2: rsp_valid=%b dp_out=%h want 0 and 01700000..01900000",
                     b1.rsp_valid, est);
        end
        tick();
        #1;
        n_checks++;
        if (b1.rsp_valid !== 1'b1) begin
            n_errors++; $display("FAIL it1_rsp_valid: got %b want 1 at A+3", b1.rsp_valid);
        end
        n_checks++;
        if (b1.rsp_data !== est) begin
            n_errors++; $display("FAIL it1_rsp_data: got %h want %h", b1.rsp_data, est);
        end
        tick();
        #1;
        n_checks++;
        if (b1.rsp_valid !== 1'b0 || b1.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL it1_after: rsp_valid=%b busy=%b want 0 0", b1.rsp_valid, b1.busy);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        b4.req0_valid = 1'b0; b4.req1_valid = 1'b0;
        b2.req0_valid = 1'b0; b2.req1_valid = 1'b0;
        b1.req0_valid = 1'b0; b1.req1_valid = 1'b0;
        b4.req0_dividend = '0; b4.req0_divisor = '0; b4.req1_dividend = '0; b4.req1_divisor = '0;
        b2.req0_dividend = '0; b2.req0_divisor = '0; b2.req1_dividend = '0; b2.req1_divisor = '0;
        b1.req0_dividend = '0; b1.req0_divisor = '0; b1.req1_dividend = '0; b1.req1_divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_tie();
        test_back_to_back();
        test_divzero();
        test_reset_mid_iter();
        test_iters1();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
